// File: rtl/vga_rect_painter_if.sv
// vga_rect_painter_if: rectangle command handshake plus video RAM write port.
interface vga_rect_painter_if #(
    parameter int COL_W = 11,
    parameter int ROW_W = 10
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [COL_W-1:0] x0;
    logic [ROW_W-1:0] y0;
    logic [COL_W-1:0] x1;
    logic [ROW_W-1:0] y1;
    logic [2:0]       color;
    logic             write_enable;
    logic [COL_W-1:0] write_col;
    logic [ROW_W-1:0] write_row;
    logic [2:0]       rgb;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid, x0, y0, x1, y1, color,
        input  cmd_ready, write_enable, write_col, write_row, rgb, busy, done
    );

    modport slave (
        input  cmd_valid, x0, y0, x1, y1, color,
        output cmd_ready, write_enable, write_col, write_row, rgb, busy, done
    );
endinterface

// File: rtl/vga_rect_painter.sv
// vga_rect_painter: clips a filled-rectangle command to the visible area and
// streams one pixel write per clock in raster order, then pulses done.
module vga_rect_painter #(
    parameter int H_VISIBLE = 640,
    parameter int V_VISIBLE = 480,
    parameter int COL_W     = 11,
    parameter int ROW_W     = 10
) (
    input logic              Clock,
    input logic              Reset,
    vga_rect_painter_if.slave bus
);
    localparam logic [COL_W-1:0] X_MAX = COL_W'(H_VISIBLE - 1);
    localparam logic [ROW_W-1:0] Y_MAX = ROW_W'(V_VISIBLE - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t           state, state_n;
    logic [COL_W-1:0] x0_q, x0_n, x1_q, x1_n, col_q, col_n, x1c;
    logic [ROW_W-1:0] y1_q, y1_n, row_q, row_n, y1c;
    logic [2:0]       color_q, color_n;
    logic             we_q, we_n, done_q, done_n;
    logic             accept, empty, row_end, last;

    // Only the far corner needs clipping; a start beyond the screen shows up as empty.
    assign x1c     = bus.x1 > X_MAX ? X_MAX : bus.x1;
    assign y1c     = bus.y1 > Y_MAX ? Y_MAX : bus.y1;
    assign empty   = bus.x0 > x1c || bus.y0 > y1c;
    assign accept  = bus.cmd_valid && state == IDLE;
    assign row_end = col_q == x1_q;
    assign last    = row_end && row_q == y1_q;

    always_comb begin
        state_n = state;
        x0_n    = x0_q;
        x1_n    = x1_q;
        y1_n    = y1_q;
        col_n   = col_q;
        row_n   = row_q;
        color_n = color_q;
        we_n    = 1'b0;
        done_n  = 1'b0;
        if (state == IDLE) begin
            if (accept) begin
                done_n = empty;
                if (!empty) begin
                    state_n = FILL;
                    we_n    = 1'b1;
                    x0_n    = bus.x0;
                    x1_n    = x1c;
                    y1_n    = y1c;
                    col_n   = bus.x0;
                    row_n   = bus.y0;
                    color_n = bus.color;
                end
            end
        end else if (last) begin
            state_n = IDLE;
            done_n  = 1'b1;
        end else begin
            we_n  = 1'b1;
            col_n = row_end ? x0_q : col_q + 1'b1;
            row_n = row_end ? row_q + 1'b1 : row_q;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= IDLE;
            x0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            col_q   <= '0;
            row_q   <= '0;
            color_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            x0_q    <= x0_n;
            x1_q    <= x1_n;
            y1_q    <= y1_n;
            col_q   <= col_n;
            row_q   <= row_n;
            color_q <= color_n;
            we_q    <= we_n;
            done_q  <= done_n;
        end
    end

    // Ready is gated by Reset so every output reads 0 while reset is held.
    assign bus.cmd_ready    = state == IDLE && !Reset;
    assign bus.busy         = state == FILL;
    assign bus.write_enable = we_q;
    assign bus.write_col    = col_q;
    assign bus.write_row    = row_q;
    assign bus.rgb          = color_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_vga_rect_painter.sv
// tb_vga_rect_painter: directed vector table plus hand-written reset and back-to-back sequences.
module tb_vga_rect_painter;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    vga_rect_painter_if #(.COL_W(11), .ROW_W(10)) bus();

    vga_rect_painter #(.H_VISIBLE(640), .V_VISIBLE(480), .COL_W(11), .ROW_W(10)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    typedef struct {
        int         x0, y0, x1, y1;
        logic [2:0] color;
        int         n, fc, fr, lc, lr;
    } vec_t;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int x0, input int y0, input int x1, input int y1, input logic [2:0] c);
        bus.x0    = 11'(x0);
        bus.y0    = 10'(y0);
        bus.x1    = 11'(x1);
        bus.y1    = 10'(y1);
        bus.color = c;
    endtask

    task automatic run_cmd(input vec_t v, input string tag);
        int writes, we_bad, done_bad, busy_bad, rdy_bad, rgb_bad, oob, fc, fr, lc, lr;
        writes = 0; we_bad = 0; done_bad = 0; busy_bad = 0; rdy_bad = 0; rgb_bad = 0; oob = 0;
        fc = -1; fr = -1; lc = -1; lr = -1;
        @(negedge Clock);
        drive(v.x0, v.y0, v.x1, v.y1, v.color);
        bus.cmd_valid = 1'b1;
        @(posedge Clock);
        #1 bus.cmd_valid = 1'b0;
        for (int k = 1; k <= v.n + 3; k++) begin
            @(negedge Clock);
            if (bus.write_enable !== 1'(k <= v.n)) we_bad++;
            if (bus.done !== 1'(k == v.n + 1)) done_bad++;
            if (bus.busy !== 1'(k <= v.n)) busy_bad++;
            if (bus.cmd_ready !== 1'(k > v.n)) rdy_bad++;
            if (bus.write_enable === 1'b1) begin
                writes++;
                if (writes == 1) begin
                    fc = int'(bus.write_col);
                    fr = int'(bus.write_row);
                end
                lc = int'(bus.write_col);
                lr = int'(bus.write_row);
                if (bus.rgb !== v.color) rgb_bad++;
                if (bus.write_col > 11'd639 || bus.write_row > 10'd479) oob++;
            end
        end
        check({tag, " writes"}, writes, v.n);
        check({tag, " we_pattern"}, we_bad, 0);
        check({tag, " done_pattern"}, done_bad, 0);
        check({tag, " busy_pattern"}, busy_bad, 0);
        check({tag, " ready_pattern"}, rdy_bad, 0);
        check({tag, " rgb"}, rgb_bad, 0);
        check({tag, " out_of_bounds"}, oob, 0);
        if (v.n > 0) begin
            check({tag, " first_col"}, fc, v.fc);
            check({tag, " first_row"}, fr, v.fr);
            check({tag, " last_col"}, lc, v.lc);
            check({tag, " last_row"}, lr, v.lr);
        end
    endtask

    vec_t vecs[8];
    vec_t one;

    initial begin
        int w, d, a_bad;
        vecs[0] = '{10, 20, 11, 21, 3'b100, 4, 10, 20, 11, 21};
        vecs[1] = '{630, 470, 700, 600, 3'b010, 100, 630, 470, 639, 479};
        vecs[2] = '{5, 0, 4, 0, 3'b111, 0, 0, 0, 0, 0};
        vecs[3] = '{700, 0, 800, 5, 3'b001, 0, 0, 0, 0, 0};
        vecs[4] = '{3, 7, 5, 7, 3'b101, 3, 3, 7, 5, 7};
        vecs[5] = '{0, 479, 2, 900, 3'b110, 3, 0, 479, 2, 479};
        vecs[6] = '{639, 0, 1000, 1, 3'b011, 2, 639, 0, 639, 1};
        vecs[7] = '{0, 480, 5, 500, 3'b111, 0, 0, 0, 0, 0};
        one     = '{0, 0, 0, 0, 3'b001, 1, 0, 0, 0, 0};

        bus.cmd_valid = 1'b0;
        drive(0, 0, 0, 0, 3'b000);
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        check("reset ready", bus.cmd_ready, 1);
        check("reset we", bus.write_enable, 0);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);

        for (int i = 0; i < 8; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

        // Reset after the third write of a 10x10 fill.
        @(negedge Clock);
        drive(0, 0, 9, 9, 3'b111);
        bus.cmd_valid = 1'b1;
        @(posedge Clock);
        #1 bus.cmd_valid = 1'b0;
        w = 0;
        repeat (3) begin
            @(negedge Clock);
            if (bus.write_enable === 1'b1) w++;
        end
        check("midreset writes_before", w, 3);
        check("midreset third_col", bus.write_col, 2);
        Reset = 1'b1;
        @(negedge Clock);
        check("midreset we", bus.write_enable, 0);
        check("midreset busy", bus.busy, 0);
        check("midreset done", bus.done, 0);
        check("midreset ready", bus.cmd_ready, 0);
        Reset = 1'b0;
        d = 0;
        repeat (5) begin
            @(negedge Clock);
            if (bus.done === 1'b1 || bus.write_enable === 1'b1) d++;
        end
        check("midreset no_done", d, 0);
        check("midreset ready_after", bus.cmd_ready, 1);
        run_cmd(one, "single");

        // Valid held high with changing data during FILL; second command taken at done.
        @(negedge Clock);
        drive(10, 20, 11, 21, 3'b100);
        bus.cmd_valid = 1'b1;
        @(posedge Clock);
        #1 drive(int'($urandom_range(0, 50)), int'($urandom_range(0, 50)),
                 int'($urandom_range(0, 50)), int'($urandom_range(0, 50)), 3'b010);
        a_bad = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clock);
            if (bus.write_enable !== 1'b1 || bus.write_col !== 11'(10 + (k - 1) % 2) ||
                bus.write_row !== 10'(20 + (k - 1) / 2) || bus.rgb !== 3'b100) a_bad++;
            drive(int'($urandom_range(0, 50)), int'($urandom_range(0, 50)),
                  int'($urandom_range(0, 50)), int'($urandom_range(0, 50)), 3'b010);
        end
        check("b2b first_cmd_pixels", a_bad, 0);
        @(negedge Clock);
        check("b2b done", bus.done, 1);
        check("b2b ready", bus.cmd_ready, 1);
        check("b2b we_gap", bus.write_enable, 0);
        drive(1, 1, 2, 1, 3'b011);
        @(posedge Clock);
        #1 bus.cmd_valid = 1'b0;
        @(negedge Clock);
        check("b2b second_we", bus.write_enable, 1);
        check("b2b second_col", bus.write_col, 1);
        check("b2b second_row", bus.write_row, 1);
        check("b2b second_rgb", bus.rgb, 3'b011);
        @(negedge Clock);
        check("b2b second_col2", bus.write_col, 2);
        @(negedge Clock);
        check("b2b second_done", bus.done, 1);
        check("b2b second_we_off", bus.write_enable, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
